// File: rtl/seg7_entry_display.sv
// Keypad-entry display buffer: right-entering digit shift buffer with backspace/clear,
// parallel seven-segment decode of every position and a time-multiplexed scan output.
module seg7_entry_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        key_in,
  input  logic                              key_valid,
  output logic [7*NUM_DIGITS-1:0]           seg_out,
  output logic [6:0]                        scan_seg,
  output logic [NUM_DIGITS-1:0]             scan_an,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              overflow
);

  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int          ND = int'(NUM_DIGITS);

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  localparam logic [6:0]            SEG_INV = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [3:0]    dig_q [NUM_DIGITS];
  logic [3:0]    dig_d [NUM_DIGITS];
  logic          occ_q [NUM_DIGITS];
  logic          occ_d [NUM_DIGITS];
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic          overflow_q, overflow_d;

  logic          presc_wrap_c;

  // Active-high gfedcba decode; empty positions are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic occ);
    logic [6:0] s;
    s = 7'b0000000;
    if (occ) begin
      case (d)
        4'd0:    s = 7'b0111111;
        4'd1:    s = 7'b0000110;
        4'd2:    s = 7'b1011011;
        4'd3:    s = 7'b1001111;
        4'd4:    s = 7'b1100110;
        4'd5:    s = 7'b1101101;
        4'd6:    s = 7'b1111101;
        4'd7:    s = 7'b0000111;
        4'd8:    s = 7'b1111111;
        4'd9:    s = 7'b1100111;
        default: s = 7'b0000000;
      endcase
    end
    return s;
  endfunction

  // Key handling: shift in digits, shift out on backspace, wipe on clear.
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      dig_d[i] = dig_q[i];
      occ_d[i] = occ_q[i];
    end
    count_d    = count_q;
    overflow_d = 1'b0;

    if (key_valid) begin
      if (key_in <= 4'd9) begin
        for (int i = ND - 1; i >= 1; i--) begin
          dig_d[i] = dig_q[i-1];
          occ_d[i] = occ_q[i-1];
        end
        dig_d[0] = key_in;
        occ_d[0] = 1'b1;
        if (count_q == CW'(NUM_DIGITS)) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (key_in == KEY_BKSP) begin
        if (count_q != '0) begin
          for (int i = 0; i < ND - 1; i++) begin
            dig_d[i] = dig_q[i+1];
            occ_d[i] = occ_q[i+1];
          end
          dig_d[ND-1] = 4'd0;
          occ_d[ND-1] = 1'b0;
          count_d     = count_q - CW'(1);
        end
      end else if (key_in == KEY_CLEAR) begin
        for (int i = 0; i < ND; i++) begin
          dig_d[i] = 4'd0;
          occ_d[i] = 1'b0;
        end
        count_d = '0;
      end
    end
  end

  // Scan prescaler and digit index; runs independently of key events.
  always_comb begin
    presc_wrap_c = (presc_q == PW'(SCAN_DIV - 1));
    presc_d      = presc_wrap_c ? '0 : presc_q + PW'(1);
    scan_idx_d   = scan_idx_q;
    if (presc_wrap_c) begin
      scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ND; i++) begin
        dig_q[i] <= 4'd0;
        occ_q[i] <= 1'b0;
      end
      count_q    <= '0;
      presc_q    <= '0;
      scan_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < ND; i++) begin
        dig_q[i] <= dig_d[i];
        occ_q[i] <= occ_d[i];
      end
      count_q    <= count_d;
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Output decode straight from registered state.
  always_comb begin
    seg_out = '0;
    for (int i = 0; i < ND; i++) begin
      seg_out[7*i +: 7] = seg_decode(dig_q[i], occ_q[i]) ^ SEG_INV;
    end
  end

  assign scan_seg    = seg_decode(dig_q[scan_idx_q], occ_q[scan_idx_q]) ^ SEG_INV;
  assign scan_an     = (NUM_DIGITS'(1) << scan_idx_q) ^ AN_INV;
  assign digit_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seg7_entry_display.sv
// Directed bench for seg7_entry_display (NUM_DIGITS=6, SCAN_DIV=4, active-high).
module tb_seg7_entry_display;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SCAN_DIV   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_in;
  logic        key_valid;
  logic [41:0] seg_out;
  logic [6:0]  scan_seg;
  logic [5:0]  scan_an;
  logic [2:0]  digit_count;
  logic        overflow;

  int errs   = 0;
  int checks = 0;

  seg7_entry_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_valid   (key_valid),
    .seg_out     (seg_out),
    .scan_seg    (scan_seg),
    .scan_an     (scan_an),
    .digit_count (digit_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = 4'h0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_seg_out",  64'(seg_out),     64'h0);
    chk("rst_count",    64'(digit_count), 64'd0);
    chk("rst_scan_an",  64'(scan_an),     64'b000001);
    chk("rst_scan_seg", 64'(scan_seg),    64'h0);
    chk("rst_overflow", 64'(overflow),    64'd0);

    // Back-to-back digit entry 1,2,3
    @(negedge clk); key_in = 4'd1; key_valid = 1'b1;
    @(negedge clk); key_in = 4'd2;
    @(negedge clk); key_in = 4'd3;
    @(negedge clk); key_valid = 1'b0;
    chk("entry_seg_out", 64'(seg_out), 64'({7'h00, 7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F}));
    chk("entry_count",   64'(digit_count), 64'd3);
    chk("entry_no_ovf",  64'(overflow), 64'd0);

    // Backspace, clear, backspace on empty, ignored code
    press(4'hA);
    chk("bksp_seg_out", 64'(seg_out), 64'({7'h00, 7'h00, 7'h00, 7'h00, 7'h06, 7'h5B}));
    chk("bksp_count",   64'(digit_count), 64'd2);
    press(4'hB);
    chk("clr_seg_out",  64'(seg_out), 64'h0);
    chk("clr_count",    64'(digit_count), 64'd0);
    press(4'hA);
    chk("bksp0_seg_out", 64'(seg_out), 64'h0);
    chk("bksp0_count",   64'(digit_count), 64'd0);
    press(4'd9);
    press(4'hE);
    chk("ign_seg_out", 64'(seg_out), 64'({7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h67}));
    chk("ign_count",   64'(digit_count), 64'd1);
    chk("ign_no_ovf",  64'(overflow), 64'd0);
    key_in = 4'd7;
    @(negedge clk);
    chk("novalid_count", 64'(digit_count), 64'd1);

    // Overflow: seven digits 0..6, pulse only after the seventh
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("ovf_low_%0d", i - 1), 64'(overflow), 64'd0);
      key_in    = 4'(i);
      key_valid = 1'b1;
    end
    @(negedge clk);
    key_valid = 1'b0;
    chk("ovf_pulse",   64'(overflow), 64'd1);
    chk("ovf_count",   64'(digit_count), 64'd6);
    chk("ovf_seg_out", 64'(seg_out), 64'({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}));
    @(negedge clk);
    chk("ovf_one_cycle", 64'(overflow), 64'd0);
    chk("ovf_count_hold", 64'(digit_count), 64'd6);

    // Scan: 8 in digit 0, index advances every SCAN_DIV cycles
    do_reset();
    key_in    = 4'd8;
    key_valid = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      key_valid = 1'b0;
      chk($sformatf("scan_an_t%0d", t), 64'(scan_an),
          64'(6'b000001 << ((t / 4) % 6)));
      chk($sformatf("scan_seg_t%0d", t), 64'(scan_seg),
          (((t / 4) % 6) == 0) ? 64'h7F : 64'h00);
    end

    // Reset wins over a simultaneous key strobe
    @(negedge clk);
    rst       = 1'b1;
    key_in    = 4'd5;
    key_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    chk("rstpri_seg_out", 64'(seg_out), 64'h0);
    chk("rstpri_count",   64'(digit_count), 64'd0);
    chk("rstpri_scan_an", 64'(scan_an), 64'b000001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seg7_entry_display.md
# seg7_entry_display

Parametrised keypad-entry display buffer for the IO matrix front end. Accepts validated 4-bit key codes from the keypad scanner, keeps a right-entering shift buffer of up to NUM_DIGITS decimal digits with backspace and clear, and decodes every position to seven-segment form. It drives both parallel per-digit segment buses and a time-multiplexed scan output (segments plus one-hot digit select) for common-anode or common-cathode boards.

## Interface
- NUM_DIGITS, 6: digit positions held and displayed; legal range 1..16.
- SCAN_DIV, 50000: clock cycles each digit stays selected on the scan outputs; must be 1 or more.
- ACTIVE_LOW, 0: 1 inverts seg_out, scan_seg and scan_an (common-anode boards).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- key_in  in  4  key code: 0x0–0x9 are digits, 0xA is backspace, 0xB is clear, 0xC–0xF are ignored.
- key_valid  in  1  one-cycle strobe qualifying key_in.
- seg_out  out  7*NUM_DIGITS  decoded segments; digit 0 (newest) is in [6:0], digit i is in [7i+6:7i].
- scan_seg  out  7  segments of the currently scanned digit.
- scan_an  out  NUM_DIGITS  one-hot digit select; bit i selects digit i.
- digit_count  out  $clog2(NUM_DIGITS+1)  number of occupied positions.
- overflow  out  1  one-cycle pulse when a digit is entered while the buffer is full.

## Operation
- State:
  - buffer of NUM_DIGITS entries, each a 4-bit value plus an occupied flag;
  - count register;
  - prescaler counting 0..SCAN_DIV-1;
  - scan index counting 0..NUM_DIGITS-1.
- Occupied positions are always contiguous from digit 0 upward, so count equals the number of occupied entries.
- Digit key (0x0–0x9) with key_valid:
  - entry i takes entry i-1 for i ≥ 1; entry 0 takes key_in and is marked occupied;
  - count becomes min(count+1, NUM_DIGITS);
  - if count was already NUM_DIGITS, the top entry is discarded and overflow pulses for one cycle.
- Backspace (0xA) with key_valid:
  - entry i takes entry i+1; the top entry becomes empty;
  - count decrements;
  - with count 0 this is a no-op.
- Clear (0xB) with key_valid: all entries become empty and count becomes 0.
- Codes 0xC–0xF, or any key_in without key_valid: no state change and no overflow pulse.
- Decode uses segment order gfedcba, bit 6 = g:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110;
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111;
  - an empty position is blank (0000000).
- ACTIVE_LOW=1 inverts all segment and anode bits, so blank reads 1111111.
- Scan:
  - the prescaler increments every cycle and wraps to 0 after SCAN_DIV-1;
  - on each wrap the scan index advances, wrapping from NUM_DIGITS-1 to 0;
  - scan_an is the one-hot of the scan index; scan_seg is the decode of buffer[scan index];
  - SCAN_DIV=1 advances the scan index every cycle.
- Reset values:
  - all entries empty, count 0, prescaler 0, scan index 0, overflow 0;
  - seg_out all blank;
  - scan_an = 1 in bit 0 (all other bits 0), inverted when ACTIVE_LOW=1;
  - scan_seg blank.

## Timing
- key_valid is sampled at edge k. Buffer, count, seg_out, digit_count and overflow reflect the key immediately after edge k (latency 1 edge).
- overflow is high for exactly the one cycle after edge k.
- seg_out and scan_seg are combinational decodes of registered state: no extra pipeline stage and no glitch-free guarantee within a cycle.
- Back-to-back key_valid on consecutive cycles is legal. Each strobe is applied in order and none are dropped.
- A key event and a prescaler wrap on the same edge are independent. The scan output shows updated buffer contents at the new scan index.
- rst has priority over key_valid and the scan logic. Asserting rst mid-entry or mid-scan returns every register to its reset value on that edge.
- Scan period: each digit is selected for SCAN_DIV cycles; a full frame is NUM_DIGITS*SCAN_DIV cycles.

## Test plan
- Bench configuration: NUM_DIGITS=6, SCAN_DIV=4, ACTIVE_LOW=0.
- Reset check: after rst, seg_out is all zeros, digit_count=0, scan_an=000001, scan_seg=0000000, overflow=0.
- Digit entry: strobe keys 1,2,3 on consecutive cycles. Then digit0=1001111 (3), digit1=1011011 (2), digit2=0000110 (1), digits 3–5 blank, digit_count=3.
- Overflow: enter 7 digits 0..6. overflow pulses one cycle on the 7th strobe only; the buffer shows 6,5,4,3,2,1 at digits 0..5 (the 0 is lost); digit_count stays 6.
- Backspace and clear: from "1,2,3", backspace leaves digit0=2 and digit1=1 with count 2. Clear then gives an all-blank buffer with count 0. A further backspace changes nothing. Key 0xE changes nothing.
- Scan: with the buffer holding 8 in digit 0, scan_an steps 000001→000010 after 4 cycles and returns to 000001 after 24 cycles. scan_seg=1111111 while bit 0 is selected and 0000000 elsewhere.
- Reset priority: assert rst in the same cycle as key_valid with key_in=5. The buffer stays empty and digit_count stays 0.
